oclib_debounced_synchronizer: RTL and testbench

Multi-channel synchronizer with per-channel glitch filtering and registered edge pulses. Brings asynchronous or noisy level signals into the `clock` domain: switches, strap pins, status from other domains, interrupt lines. Generalises the plain flop-chain synchronizer with three additions: a reset value, a stability (debounce) filter, and rise/fall event outputs, so consumers no longer hand-build filters behind a synchronizer.

---
 rtl/oclib_debounced_synchronizer.sv | 109 ++++++++++
 tb/tb_oclib_debounced_synchronizer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/oclib_debounced_synchronizer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : oclib_debounced_synchronizer                                     |
// | Brief   : per-channel flop-chain synchronizer, stability filter, edge      |
// |           pulses; define OC_DEBOUNCED_SYNC_EDGE_EN to build rise/fall.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module oclib_debounced_synchronizer #(
  parameter int               Width          = 1,
  parameter int               SyncCycles     = 3,
  parameter int               DebounceCycles = 1,
  parameter logic [Width-1:0] ResetValue     = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [Width-1:0] in,
  output logic [Width-1:0] out,
  output logic [Width-1:0] rise,
  output logic [Width-1:0] fall,
  output logic [Width-1:0] pending
);

  localparam int                 c_CNT_W    = $clog2(DebounceCycles + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DebounceCycles - 1);

  logic [Width-1:0] w_sync;

  generate
    if (SyncCycles == 1 || SyncCycles > 10) begin : g_bad_sync
      $error("SyncCycles must be 0 or 2..10");
    end
    if (DebounceCycles < 1 || DebounceCycles > 65535) begin : g_bad_debounce
      $error("DebounceCycles must be 1..65535");
    end

    if (SyncCycles == 0) begin : g_bypass
      assign w_sync = in;
    end else begin : g_chain
      logic [Width-1:0] r_chain [SyncCycles];

      always_ff @(posedge clock) begin
        if (reset) begin
          for (int s = 0; s < SyncCycles; s++) r_chain[s] <= ResetValue;
        end else begin
          r_chain[0] <= in;
          for (int s = 1; s < SyncCycles; s++) r_chain[s] <= r_chain[s-1];
        end
      end

      assign w_sync = r_chain[SyncCycles-1];
    end

    for (genvar i = 0; i < Width; i++) begin : g_ch
      logic [c_CNT_W-1:0] r_cnt;
      logic [c_CNT_W-1:0] w_cnt_nxt;
      logic               r_out;
      logic               r_pend;
      logic               w_differs;
      logic               w_qualify;

      assign w_differs = w_sync[i] ^ r_out;
      assign w_qualify = w_differs && (r_cnt == c_CNT_LAST);

      // Counter stops at c_CNT_LAST: the qualifying edge clears it instead of wrapping.
      always_comb begin
        w_cnt_nxt = '0;
        if (w_differs && !w_qualify) w_cnt_nxt = r_cnt + c_CNT_W'(1);
      end

      always_ff @(posedge clock) begin
        if (reset) begin
          r_cnt  <= '0;
          r_out  <= ResetValue[i];
          r_pend <= 1'b0;
        end else begin
          r_cnt  <= w_cnt_nxt;
          r_pend <= |w_cnt_nxt;
          if (w_qualify) r_out <= w_sync[i];
        end
      end

      assign out[i]     = r_out;
      assign pending[i] = r_pend;

`ifdef OC_DEBOUNCED_SYNC_EDGE_EN
      logic r_rise;
      logic r_fall;

      always_ff @(posedge clock) begin
        if (reset) begin
          r_rise <= 1'b0;
          r_fall <= 1'b0;
        end else begin
          r_rise <= w_qualify &  w_sync[i];
          r_fall <= w_qualify & ~w_sync[i];
        end
      end

      assign rise[i] = r_rise;
      assign fall[i] = r_fall;
`else
      assign rise[i] = 1'b0;
      assign fall[i] = 1'b0;
`endif
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_oclib_debounced_synchronizer.sv
`default_nettype none
// Bench for oclib_debounced_synchronizer: 4-channel filtered instance plus a
// bypass instance, both checked each cycle against a window-based model.
`timescale 1ns/1ps
module tb_oclib_debounced_synchronizer;

  localparam logic [3:0] RV = 4'b1010;
`ifdef OC_DEBOUNCED_SYNC_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] in_a  = RV;
  logic [3:0] out_a, rise_a, fall_a, pend_a;
  logic [3:0] in_b  = 4'b0000;
  logic [3:0] out_b, rise_b, fall_b, pend_b;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clock = ~clock;

  oclib_debounced_synchronizer #(
    .Width(4), .SyncCycles(3), .DebounceCycles(4), .ResetValue(RV)
  ) dut_a (
    .clock(clock), .reset(reset), .in(in_a),
    .out(out_a), .rise(rise_a), .fall(fall_a), .pending(pend_a)
  );

  oclib_debounced_synchronizer #(
    .Width(4), .SyncCycles(0), .DebounceCycles(1), .ResetValue(4'b0000)
  ) dut_b (
    .clock(clock), .reset(reset), .in(in_b),
    .out(out_b), .rise(rise_b), .fall(fall_b), .pending(pend_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: sync is the input seen SyncCycles edges earlier; out flips once the
  // last DebounceCycles sync samples all disagree with it.
  logic [3:0] m_dly  [3];
  logic [3:0] m_hist [4];
  logic [3:0] m_out, m_rise, m_fall, m_pend, m_prev, m_s;
  logic [3:0] mb_out, mb_rise, mb_fall;
  bit         valid = 1'b0;

  always @(posedge clock) begin
    cyc++;
    if (reset) begin
      for (int k = 0; k < 3; k++) m_dly[k] = RV;
      for (int k = 0; k < 4; k++) m_hist[k] = RV;
      m_out = RV; m_rise = '0; m_fall = '0; m_pend = '0;
      mb_out = '0; mb_rise = '0; mb_fall = '0;
      valid = 1'b1;
    end else begin
      m_s = m_dly[2];
      m_dly[2] = m_dly[1]; m_dly[1] = m_dly[0]; m_dly[0] = in_a;
      for (int k = 3; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = m_s;
      m_prev = m_out;
      for (int ch = 0; ch < 4; ch++) begin
        if (m_hist[0][ch] != m_prev[ch] && m_hist[1][ch] != m_prev[ch] &&
            m_hist[2][ch] != m_prev[ch] && m_hist[3][ch] != m_prev[ch])
          m_out[ch] = ~m_prev[ch];
      end
      m_rise = EDGE ? (m_out & ~m_prev) : 4'b0000;
      m_fall = EDGE ? (~m_out & m_prev) : 4'b0000;
      m_pend = m_hist[0] ^ m_out;
      mb_rise = EDGE ? (in_b & ~mb_out) : 4'b0000;
      mb_fall = EDGE ? (~in_b & mb_out) : 4'b0000;
      mb_out  = in_b;
    end
  end

  always @(negedge clock) begin
    if (valid) begin
      chk("a_out",  out_a,  m_out);
      chk("a_rise", rise_a, m_rise);
      chk("a_fall", fall_a, m_fall);
      chk("a_pend", pend_a, m_pend);
      chk("b_out",  out_b,  mb_out);
      chk("b_rise", rise_b, mb_rise);
      chk("b_fall", fall_b, mb_fall);
      chk("b_pend", pend_b, 4'b0000);
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      in_b = 4'($urandom);
    end
  end

  initial begin
    int e, t_up, t_dn, pcnt, rcnt, fcnt, ohi, r0, f3;

    // Reset with input equal to the reset value
    reset = 1'b1;
    in_a  = RV;
    repeat (3) begin
      @(negedge clock);
      chk("rst_out", out_a, RV);
      chk("rst_flags", {rise_a, fall_a, pend_a}, 12'h000);
    end
    reset = 1'b0;
    repeat (6) begin
      @(negedge clock);
      chk("post_rst_out", out_a, RV);
      chk("post_rst_flags", {rise_a, fall_a, pend_a}, 12'h000);
    end

    // Latency: step in[0] 0->1
    in_a[0] = 1'b1;
    e = cyc + 1; t_up = -1; pcnt = 0; rcnt = 0;
    repeat (12) begin
      @(negedge clock);
      if (out_a[0] && t_up < 0) t_up = cyc;
      pcnt += int'(pend_a[0]);
      rcnt += int'(rise_a[0]);
    end
    chk("lat_edges", t_up - e + 1, 7);
    chk("lat_pending_cycles", pcnt, 3);
    chk("lat_rise_count", rcnt, EDGE ? 1 : 0);

    // Glitch of 3 cycles on in[2] is rejected
    pcnt = 0; rcnt = 0; ohi = 0;
    for (int k = 0; k < 15; k++) begin
      in_a[2] = (k < 3);
      @(negedge clock);
      pcnt += int'(pend_a[2]);
      rcnt += int'(rise_a[2] | fall_a[2]);
      ohi  += int'(out_a[2]);
    end
    chk("glitch_out_high", ohi, 0);
    chk("glitch_pending_cycles", pcnt, 3);
    chk("glitch_pending_clear", pend_a[2], 1'b0);
    chk("glitch_edges", rcnt, 0);

    // A 4-cycle pulse qualifies: rise then fall, output high 4 cycles
    rcnt = 0; fcnt = 0; ohi = 0; t_up = -1; t_dn = -1;
    for (int k = 0; k < 20; k++) begin
      in_a[2] = (k < 4);
      @(negedge clock);
      if (rise_a[2]) begin rcnt++; t_up = cyc; end
      if (fall_a[2]) begin fcnt++; t_dn = cyc; end
      ohi += int'(out_a[2]);
    end
    chk("pulse_out_high_cycles", ohi, 4);
    chk("pulse_rise_count", rcnt, EDGE ? 1 : 0);
    chk("pulse_fall_count", fcnt, EDGE ? 1 : 0);
    chk("pulse_fall_after_rise", t_dn - t_up, EDGE ? 4 : 0);

    // Independent channels: in[0] rises while in[3] falls
    in_a[0] = 1'b0;
    repeat (10) @(negedge clock);
    in_a[0] = 1'b1;
    in_a[3] = 1'b0;
    e = cyc + 1; t_up = -1; t_dn = -1; r0 = -1; f3 = -1;
    repeat (12) begin
      @(negedge clock);
      if (out_a[0] && t_up < 0) t_up = cyc;
      if (!out_a[3] && t_dn < 0) t_dn = cyc;
      if (rise_a[0]) r0 = cyc;
      if (fall_a[3]) f3 = cyc;
    end
    chk("indep_out0_latency", t_up - e + 1, 7);
    chk("indep_same_cycle", t_dn, t_up);
    chk("indep_rise0_cycle", r0, EDGE ? t_up : -1);
    chk("indep_fall3_cycle", f3, EDGE ? t_up : -1);
    chk("indep_others", out_a[2:1], 2'b01);

    // Reset while in[2] is two counts into qualification
    in_a[2] = 1'b1;
    repeat (5) @(negedge clock);
    chk("midq_pending_before", pend_a[2], 1'b1);
    reset = 1'b1;
    @(negedge clock);
    chk("midq_out_reset", out_a, RV);
    chk("midq_flags", {rise_a, fall_a, pend_a}, 12'h000);
    reset = 1'b0;
    e = cyc + 1; t_up = -1;
    repeat (12) begin
      @(negedge clock);
      if (out_a != RV && t_up < 0) t_up = cyc;
    end
    chk("midq_restart_latency", t_up - e + 1, 7);
    chk("midq_final_out", out_a, 4'b0111);

    // Noisy random input on the filtered instance, bypass keeps running
    for (int k = 0; k < 1000; k++) begin
      for (int ch = 0; ch < 4; ch++)
        if ($urandom_range(3) == 0) in_a[ch] = ~in_a[ch];
      @(negedge clock);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
